// File: rtl/prb_seq.sv
// Sequential PRB mask unit: latches N operands, registers relevance / leading-zero
// masks, then streams a masked SC index for exactly 2^k beats and pulses done.
module prb_seq #(
  parameter int W        = 8,
  parameter int N        = 2,
  parameter int CORR     = 0,
  parameter int S_GROUPS = (CORR != 0) ? 1 : N
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N-1:0][W-1:0]          Bxs,
  output logic [S_GROUPS-1:0][W-1:0]   S,
  output logic [W-1:0]                 ell,
  output logic [$clog2(W+1)-1:0]       len,
  output logic [W-1:0]                 cnt,
  output logic                         cnt_valid,
  input  logic                         cnt_ready,
  output logic                         done
);

  localparam int LW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, RUN, DONE} state_t;

  state_t                      state, state_nxt;
  logic [N-1:0][W-1:0]         bxs_q;
  logic [W:0]                  c;
  logic [LW-1:0]               tz_q;
  logic [W-1:0]                bx_or;
  logic [W-1:0]                ell_c;
  logic [W-1:0]                tzd_or;
  logic [S_GROUPS-1:0][W-1:0]  s_c;
  logic [LW-1:0]               len_c;
  logic [LW-1:0]               tz_c;
  logic [W:0]                  last_c;

  // Ones strictly below the lowest set bit; x | -x covers that bit and everything above.
  function automatic logic [W-1:0] tzd(input logic [W-1:0] x);
    logic [W-1:0] neg;
    neg = -x;
    return ~(x | neg);
  endfunction

  function automatic logic [W-1:0] lzd(input logic [W-1:0] x);
    logic [W-1:0] r;
    logic         seen;
    r    = '0;
    seen = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      seen = seen | x[i];
      r[i] = ~seen;
    end
    return r;
  endfunction

  function automatic int popcnt(input logic [W-1:0] x);
    int s;
    s = 0;
    for (int i = 0; i < W; i++) s += int'(x[i]);
    return s;
  endfunction

  // NOTE: every signal written in an always_comb gets a default before any branch, so no latch is inferred.
  always_comb begin
    bx_or = '0;
    for (int i = 0; i < N; i++) bx_or = bx_or | bxs_q[i];
  end

  // k = m - tz + 1 is the width of the span between the leading and trailing zero masks.
  always_comb begin
    ell_c  = lzd(bx_or);
    tzd_or = tzd(bx_or);
    tz_c   = LW'(popcnt(tzd_or));
    len_c  = (bx_or == '0) ? '0 : LW'(W - popcnt(ell_c) - popcnt(tzd_or));
    s_c    = '1;
    for (int g = 0; g < S_GROUPS; g++)
      s_c[g] = ((CORR != 0) ? tzd_or : tzd(bxs_q[g])) | ell_c;
  end

  assign last_c = ({{W{1'b0}}, 1'b1} << len) - 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = CALC;
      CALC: state_nxt = (bx_or != '0) ? RUN : DONE;
      RUN:  if (cnt_ready && (c == last_c)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      S     <= '1;
      ell   <= '1;
      len   <= '0;
      tz_q  <= '0;
      c     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        CALC: begin
          S    <= s_c;
          ell  <= ell_c;
          len  <= len_c;
          tz_q <= tz_c;
          c    <= '0;
        end
        RUN:     if (cnt_ready) c <= c + 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the operand buffer is pure datapath and needs no reset; CALC only reads it after an accept.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) bxs_q <= Bxs;
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign in_ready  = (state == IDLE);
  assign cnt_valid = (state == RUN);
  assign done      = (state == DONE);
  assign cnt       = cnt_valid ? (c[W-1:0] << tz_q) : '0;

endmodule

// File: tb/tb_prb_seq.sv
// Self-checking bench for prb_seq: directed runs from the test plan plus random
// operand/backpressure runs, checked against an arithmetic reference model.
module tb_prb_seq;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             cnt_ready;
  logic [1:0][7:0]  bxs;

  logic             in_ready0, in_ready1;
  logic [1:0][7:0]  s0;
  logic [0:0][7:0]  s1;
  logic [7:0]       ell0, ell1, cnt0, cnt1;
  logic [3:0]       len0, len1;
  logic             cnt_valid0, cnt_valid1, done0, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prb_seq #(.W(8), .N(2), .CORR(0)) u_corr0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .Bxs(bxs),
    .S(s0), .ell(ell0), .len(len0), .cnt(cnt0), .cnt_valid(cnt_valid0),
    .cnt_ready(cnt_ready), .done(done0)
  );

  prb_seq #(.W(8), .N(2), .CORR(1)) u_corr1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .Bxs(bxs),
    .S(s1), .ell(ell1), .len(len1), .cnt(cnt1), .cnt_valid(cnt_valid1),
    .cnt_ready(cnt_ready), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operand values.
  function automatic int highest(input int x);
    int h;
    h = -1;
    for (int i = 0; i < 8; i++) if ((x >> i) & 1) h = i;
    return h;
  endfunction

  function automatic int ref_tzd(input int x);
    if (x == 0) return 8'hFF;
    return (x & -x) - 1;
  endfunction

  function automatic int ref_lzd(input int x);
    if (x == 0) return 8'hFF;
    return (8'hFF << (highest(x) + 1)) & 8'hFF;
  endfunction

  function automatic int ref_tz(input int x);
    return (x == 0) ? 8 : $clog2(x & -x);
  endfunction

  function automatic int ref_k(input int x);
    return (x == 0) ? 0 : highest(x) - ref_tz(x) + 1;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready0}, 32'd1);
    check({tag, "_S0"}, {16'd0, s0}, 32'hFFFF);
    check({tag, "_S1"}, {24'd0, s1}, 32'hFF);
    check({tag, "_ell"}, {24'd0, ell0}, 32'hFF);
    check({tag, "_len"}, {28'd0, len0}, 32'd0);
    check({tag, "_cnt"}, {24'd0, cnt0}, 32'd0);
    check({tag, "_cnt_valid"}, {30'd0, cnt_valid0, cnt_valid1}, 32'd0);
    check({tag, "_done"}, {30'd0, done0, done1}, 32'd0);
  endtask

  // One operand set end to end. stall_beat/stall_cycles hold cnt_ready low at that beat,
  // rnd_ready randomises cnt_ready, rst_beat >= 0 resets when that beat is on cnt.
  task automatic do_run(input int a, input int b, input int stall_beat, input int stall_cycles,
                        input bit rnd_ready, input int rst_beat, input bit poke_valid);
    int bor, tz, k, beats, idx, stalls, cycles;
    bit ready;
    bor   = a | b;
    tz    = ref_tz(bor);
    k     = ref_k(bor);
    beats = (bor == 0) ? 0 : (1 << k);

    @(negedge clk);
    check("accept_in_ready", {31'd0, in_ready0}, 32'd1);
    in_valid = 1'b1;
    bxs      = {b[7:0], a[7:0]};
    @(negedge clk);
    in_valid = 1'b0;
    bxs      = '0;
    check("calc_in_ready", {30'd0, in_ready0, in_ready1}, 32'd0);
    check("calc_cnt_valid", {31'd0, cnt_valid0}, 32'd0);

    @(negedge clk);
    check("S0_0", {24'd0, s0[0]}, 32'(ref_tzd(a) | ref_lzd(bor)));
    check("S0_1", {24'd0, s0[1]}, 32'(ref_tzd(b) | ref_lzd(bor)));
    check("S1_0", {24'd0, s1[0]}, 32'(ref_tzd(bor) | ref_lzd(bor)));
    check("ell", {16'd0, ell1, ell0}, 32'(ref_lzd(bor) * 257));
    check("len", {24'd0, len1, len0}, 32'(k * 17));

    if (beats == 0) begin
      check("zero_done", {30'd0, done0, done1}, 32'd3);
      check("zero_cnt_valid", {31'd0, cnt_valid0}, 32'd0);
      @(negedge clk);
      check("zero_in_ready", {31'd0, in_ready0}, 32'd1);
      check("zero_done_end", {31'd0, done0}, 32'd0);
      return;
    end

    idx = 0; stalls = 0; cycles = 0;
    while (idx < beats && cycles < 4000) begin
      check("beat_valid", {30'd0, cnt_valid0, cnt_valid1}, 32'd3);
      check("beat_cnt0", {24'd0, cnt0}, 32'((idx << tz) & 8'hFF));
      check("beat_cnt1", {24'd0, cnt1}, 32'((idx << tz) & 8'hFF));
      if (poke_valid) begin
        in_valid = 1'b1;
        check("run_in_ready", {31'd0, in_ready0}, 32'd0);
      end
      if (rst_beat >= 0 && idx == rst_beat) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("midrun_rst");
        @(negedge clk);
        check("post_rst_done", {30'd0, done0, done1}, 32'd0);
        check("post_rst_in_ready", {31'd0, in_ready0}, 32'd1);
        return;
      end
      if (rnd_ready) ready = ($urandom_range(0, 3) != 0);
      else           ready = !(idx == stall_beat && stalls < stall_cycles);
      if (!ready) stalls++;
      cnt_ready = ready;
      @(negedge clk);
      cycles++;
      if (ready) idx++;
    end
    in_valid  = 1'b0;
    cnt_ready = 1'b1;
    check("run_cycles", 32'(cycles), 32'(beats + stalls));
    check("end_done", {30'd0, done0, done1}, 32'd3);
    check("end_cnt_valid", {31'd0, cnt_valid0}, 32'd0);
    @(negedge clk);
    check("end_done_clear", {31'd0, done0}, 32'd0);
    check("end_in_ready", {31'd0, in_ready0}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    cnt_ready = 1'b1;
    bxs       = '0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    do_run(8'h2C, 8'h06, -1, 0, 1'b0, -1, 1'b0);
    do_run(8'h00, 8'h00, -1, 0, 1'b0, -1, 1'b0);
    do_run(8'h80, 8'h00, -1, 0, 1'b0, -1, 1'b0);
    do_run(8'h2C, 8'h06, 8, 3, 1'b0, -1, 1'b1);
    do_run(8'h2C, 8'h06, -1, 0, 1'b0, 16, 1'b0);
    do_run(8'h2C, 8'h06, -1, 0, 1'b0, -1, 1'b0);
    do_run(8'hFF, 8'h01, -1, 0, 1'b0, -1, 1'b0);

    for (int r = 0; r < 16; r++) begin
      int a, b;
      a = $urandom_range(0, 255) & ($urandom_range(0, 1) ? 8'hFF : 8'h3C);
      b = $urandom_range(0, 255) & ($urandom_range(0, 1) ? 8'hFF : 8'h00);
      do_run(a, b, -1, 0, 1'b1, -1, r[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
